// File: rtl/serial_cmd_engine_pkg.sv
// Shared opcodes, reset values, FSM state encoding and opcode decode helpers
// for the UART command engine.
package serial_cmd_pkg;

    localparam logic [7:0] OP_VERSION   = 8'h00;
    localparam logic [7:0] OP_COINC     = 8'h01;
    localparam logic [7:0] OP_SEED      = 8'h06;
    localparam logic [7:0] OP_PRESCALE  = 8'h07;
    localparam logic [7:0] OP_HIST      = 8'h0A;
    localparam logic [7:0] OP_DEAD      = 8'h0B;
    localparam logic [7:0] OP_MASK      = 8'h0E;
    localparam logic [7:0] OP_TRIGNUM   = 8'h0F;
    localparam logic [7:0] OP_COUNTERS  = 8'h10;
    localparam logic [7:0] OP_RSTCLK    = 8'h11;
    localparam logic [7:0] OP_NLAYER    = 8'h13;
    localparam logic [7:0] OP_NHIT      = 8'h14;
    localparam logic [7:0] OP_READBACK  = 8'h15;

    localparam logic [7:0] NAK          = 8'hFF;
    localparam logic [7:0] COINC_LIMIT  = 8'd64;

    localparam logic [7:0]  COINC_RST    = 8'd20;
    localparam logic [7:0]  DEAD_RST     = 8'd50;
    localparam logic [63:0] MASK_RST     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] PRESCALE_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_EXEC,
        ST_SEND,
        ST_SEND_WAIT
    } state_e;

    function automatic logic [3:0] argCount(input logic [7:0] op);
        case (op)
            OP_COINC, OP_DEAD, OP_TRIGNUM, OP_NLAYER, OP_NHIT: argCount = 4'd1;
            OP_SEED, OP_PRESCALE:                              argCount = 4'd4;
            OP_MASK:                                           argCount = 4'd8;
            default:                                           argCount = 4'd0;
        endcase
    endfunction

    function automatic logic isKnown(input logic [7:0] op);
        case (op)
            OP_VERSION, OP_COINC, OP_SEED, OP_PRESCALE, OP_HIST, OP_DEAD,
            OP_MASK, OP_TRIGNUM, OP_COUNTERS, OP_RSTCLK, OP_NLAYER,
            OP_NHIT, OP_READBACK: isKnown = 1'b1;
            default:              isKnown = 1'b0;
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        imax = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_cmd_engine_if.sv
// Byte-level link between the UART rx/tx cores and the command engine.
interface serial_cmd_engine_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
    modport slave  (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/serial_cmd_engine_byte_sender.sv
// Streams len_i bytes to the UART transmitter; the caller maps idx_o to byte_i.
module serial_byte_sender
    import serial_cmd_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [IDX_W-1:0] idx_o,
    input  logic [7:0]       byte_i,
    input  logic             tx_busy_i,
    output logic             tx_start_o,
    output logic [7:0]       tx_data_o,
    output logic             done_o
);

    state_e           phase_q;
    logic [IDX_W-1:0] idx_q;
    logic             txStart_q;
    logic [7:0]       txData_q;

    assign done_o = (phase_q == ST_SEND_WAIT) && (LEN_W'(idx_q) == len_i - LEN_W'(1));

    // SEND_WAIT gives the transmitter one cycle to raise tx_busy before we look again
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= ST_IDLE;
            idx_q     <= '0;
            txStart_q <= 1'b0;
            txData_q  <= 8'h00;
        end else begin
            txStart_q <= 1'b0;
            case (phase_q)
                ST_SEND: begin
                    if (!tx_busy_i) begin
                        txData_q  <= byte_i;
                        txStart_q <= 1'b1;
                        phase_q   <= ST_SEND_WAIT;
                    end
                end
                ST_SEND_WAIT: begin
                    if (done_o) begin
                        phase_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        phase_q <= ST_SEND;
                    end
                end
                default: begin
                    if (start_i) begin
                        idx_q   <= '0;
                        phase_q <= ST_SEND;
                    end
                end
            endcase
        end
    end

    assign idx_o      = idx_q;
    assign tx_start_o = txStart_q;
    assign tx_data_o  = txData_q;

endmodule

// File: rtl/serial_cmd_engine.sv
// UART command processor: decodes opcodes with fixed-length arguments, updates
// trigger configuration and streams snapshot replies through the byte sender.
module serial_cmd_engine
    import serial_cmd_pkg::*;
#(
    parameter int         NCH        = 8,
    parameter int         HIST_W     = 32,
    parameter int         CNT_W      = 56,
    parameter int         TIMEOUT    = 1000000,
    parameter logic [7:0] FW_VERSION = 8'd9
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_cmd_engine_if.slave    bus,
    input  logic [NCH*HIST_W-1:0] histos_i,
    input  logic [NCH*CNT_W-1:0]  clock_counter_i,
    input  logic [NCH*8-1:0]      trigger_fired_i,
    output logic [7:0]            coincidence_time_o,
    output logic [7:0]            dead_time_o,
    output logic [7:0]            trigger_number_o,
    output logic [7:0]            n_layer_threshold_o,
    output logic [7:0]            n_hit_threshold_o,
    output logic [63:0]           trigger_mask_o,
    output logic [31:0]           prescale_o,
    output logic [31:0]           seed_o,
    output logic                  set_seed_o,
    output logic                  reset_hist_o,
    output logic                  reset_out_o,
    output logic                  reset_clock_o,
    output logic [7:0]            err_count_o
);

    localparam int CNT_BYTES = CNT_W / 8;
    localparam int HIST_LEN  = NCH * HIST_W / 8;
    localparam int CNT_LEN   = NCH * (CNT_BYTES + 1);
    localparam int MAX_LEN   = imax(imax(HIST_LEN, CNT_LEN), 5);
    localparam int IDX_W     = $clog2(MAX_LEN);
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int RB_W      = MAX_LEN * 8;
    localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q;
    logic [7:0]        opcode_q;
    logic [2:0]        argCnt_q;
    logic [63:0]       args_q;
    logic [TW-1:0]     timer_q;
    logic [7:0]        coinc_q, dead_q, trigNum_q, nLayer_q, nHit_q, errCount_q;
    logic [63:0]       mask_q;
    logic [31:0]       prescale_q, seed_q;
    logic              setSeed_q, resetHist_q, resetOut_q, resetClock_q;
    logic [RB_W-1:0]   replyBuf_q, replyBuf_d;
    logic [LEN_W-1:0]  replyLen_q, replyLen_d;
    logic              errEvent, timeoutHit, lastArg;
    logic [IDX_W-1:0]  sendIdx;
    logic [7:0]        sendByte;
    logic              sendDone, sendStart;

    assign timeoutHit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);
    assign lastArg    = (({1'b0, argCnt_q} + 4'd1) == argCount(opcode_q));
    assign sendStart  = (state_q == ST_EXEC) && (replyLen_d != '0);
    assign sendByte   = 8'(replyBuf_q >> {sendIdx, 3'b000});

    // Reply image captured in EXEC so the streamed bytes cannot shift under us
    always_comb begin
        replyBuf_d = '0;
        replyLen_d = '0;
        case (opcode_q)
            OP_VERSION: begin
                replyBuf_d[7:0] = FW_VERSION;
                replyLen_d      = LEN_W'(1);
            end
            OP_HIST: begin
                replyBuf_d[HIST_LEN*8-1:0] = histos_i;
                replyLen_d                 = LEN_W'(HIST_LEN);
            end
            OP_COUNTERS: begin
                for (int c = 0; c < NCH; c++) begin
                    replyBuf_d[c*(CNT_BYTES+1)*8 +: CNT_W]         = clock_counter_i[c*CNT_W +: CNT_W];
                    replyBuf_d[(c*(CNT_BYTES+1)+CNT_BYTES)*8 +: 8] = trigger_fired_i[c*8 +: 8];
                end
                replyLen_d = LEN_W'(CNT_LEN);
            end
            OP_RSTCLK: begin
                replyBuf_d[7:0] = OP_RSTCLK;
                replyLen_d      = LEN_W'(1);
            end
            OP_READBACK: begin
                replyBuf_d[39:0] = {nHit_q, nLayer_q, trigNum_q, dead_q, coinc_q};
                replyLen_d       = LEN_W'(5);
            end
            default: begin
                if (!isKnown(opcode_q)) begin
                    replyBuf_d[7:0] = NAK;
                    replyLen_d      = LEN_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        errEvent = 1'b0;
        if (state_q == ST_ARGS && !bus.rx_ready && timeoutHit) begin
            errEvent = 1'b1;
        end
        if (state_q == ST_EXEC &&
            (!isKnown(opcode_q) || (opcode_q == OP_COINC && args_q[7:0] >= COINC_LIMIT))) begin
            errEvent = 1'b1;
        end
    end

    // Command FSM; configuration registers and pulses all change on the EXEC edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            opcode_q     <= 8'h00;
            argCnt_q     <= '0;
            args_q       <= '0;
            timer_q      <= '0;
            coinc_q      <= COINC_RST;
            dead_q       <= DEAD_RST;
            trigNum_q    <= 8'h00;
            nLayer_q     <= 8'h00;
            nHit_q       <= 8'h00;
            mask_q       <= MASK_RST;
            prescale_q   <= PRESCALE_RST;
            seed_q       <= '0;
            setSeed_q    <= 1'b0;
            resetHist_q  <= 1'b0;
            resetOut_q   <= 1'b0;
            resetClock_q <= 1'b0;
            errCount_q   <= 8'h00;
            replyBuf_q   <= '0;
            replyLen_q   <= '0;
        end else begin
            setSeed_q    <= 1'b0;
            resetHist_q  <= 1'b0;
            resetOut_q   <= 1'b0;
            resetClock_q <= 1'b0;
            if (errEvent && errCount_q != 8'hFF) begin
                errCount_q <= errCount_q + 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_ready) begin
                        opcode_q <= bus.rx_data;
                        argCnt_q <= '0;
                        args_q   <= '0;
                        timer_q  <= '0;
                        state_q  <= (argCount(bus.rx_data) != 4'd0) ? ST_ARGS : ST_EXEC;
                    end
                end
                ST_ARGS: begin
                    if (bus.rx_ready) begin
                        args_q[{argCnt_q, 3'b000} +: 8] <= bus.rx_data;
                        argCnt_q <= argCnt_q + 3'd1;
                        timer_q  <= '0;
                        if (lastArg) begin
                            state_q <= ST_EXEC;
                        end
                    end else if (timeoutHit) begin
                        args_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_EXEC: begin
                    case (opcode_q)
                        OP_COINC: begin
                            if (args_q[7:0] < COINC_LIMIT) begin
                                coinc_q <= args_q[7:0];
                            end
                        end
                        OP_SEED: begin
                            seed_q    <= args_q[31:0];
                            setSeed_q <= 1'b1;
                        end
                        OP_PRESCALE: prescale_q   <= args_q[31:0];
                        OP_HIST:     resetHist_q  <= 1'b1;
                        OP_DEAD:     dead_q       <= args_q[7:0];
                        OP_MASK:     mask_q       <= args_q;
                        OP_TRIGNUM:  trigNum_q    <= args_q[7:0];
                        OP_COUNTERS: resetOut_q   <= 1'b1;
                        OP_RSTCLK:   resetClock_q <= 1'b1;
                        OP_NLAYER:   nLayer_q     <= args_q[7:0];
                        OP_NHIT:     nHit_q       <= args_q[7:0];
                        default: ;
                    endcase
                    replyBuf_q <= replyBuf_d;
                    replyLen_q <= replyLen_d;
                    state_q    <= (replyLen_d != '0) ? ST_SEND : ST_IDLE;
                end
                ST_SEND: begin
                    if (sendDone) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    serial_byte_sender #(
        .IDX_W (IDX_W),
        .LEN_W (LEN_W)
    ) u_sender (
        .clk        (clk),
        .reset      (reset),
        .start_i    (sendStart),
        .len_i      (replyLen_q),
        .idx_o      (sendIdx),
        .byte_i     (sendByte),
        .tx_busy_i  (bus.tx_busy),
        .tx_start_o (bus.tx_start),
        .tx_data_o  (bus.tx_data),
        .done_o     (sendDone)
    );

    assign coincidence_time_o  = coinc_q;
    assign dead_time_o         = dead_q;
    assign trigger_number_o    = trigNum_q;
    assign n_layer_threshold_o = nLayer_q;
    assign n_hit_threshold_o   = nHit_q;
    assign trigger_mask_o      = mask_q;
    assign prescale_o          = prescale_q;
    assign seed_o              = seed_q;
    assign set_seed_o          = setSeed_q;
    assign reset_hist_o        = resetHist_q;
    assign reset_out_o         = resetOut_q;
    assign reset_clock_o       = resetClock_q;
    assign err_count_o         = errCount_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed bench for serial_cmd_engine: a vector table for register writes and
// short replies, plus hand-written snapshot, timeout, saturation and reset sequences.
module tb_serial_cmd_engine;
    import serial_cmd_pkg::*;

    localparam int NCH     = 8;
    localparam int HIST_W  = 32;
    localparam int CNT_W   = 56;
    localparam int TIMEOUT = 100;

    localparam int F_NONE = 0, F_COINC = 1, F_DEAD = 2, F_TRIG = 3, F_NLAYER = 4;
    localparam int F_NHIT = 5, F_MASK = 6, F_PRESCALE = 7, F_SEED = 8;

    typedef struct {
        logic [7:0]  op;
        int          nArgs;
        logic [63:0] args;
        int          field;
        logic [63:0] expField;
        logic [7:0]  expErr;
        int          expLen;
        logic [63:0] expReply;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NCH*HIST_W-1:0] histos;
    logic [NCH*CNT_W-1:0]  counters;
    logic [NCH*8-1:0]      trigFired;
    logic [7:0]  coincTime, deadTime, trigNum, nLayer, nHit, errCount;
    logic [63:0] trigMask;
    logic [31:0] prescale, seed;
    logic        setSeed, resetHist, resetOut, resetClock;

    serial_cmd_engine_if bus();

    serial_cmd_engine #(
        .NCH        (NCH),
        .HIST_W     (HIST_W),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .FW_VERSION (8'd9)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus.slave),
        .histos_i            (histos),
        .clock_counter_i     (counters),
        .trigger_fired_i     (trigFired),
        .coincidence_time_o  (coincTime),
        .dead_time_o         (deadTime),
        .trigger_number_o    (trigNum),
        .n_layer_threshold_o (nLayer),
        .n_hit_threshold_o   (nHit),
        .trigger_mask_o      (trigMask),
        .prescale_o          (prescale),
        .seed_o              (seed),
        .set_seed_o          (setSeed),
        .reset_hist_o        (resetHist),
        .reset_out_o         (resetOut),
        .reset_clock_o       (resetClock),
        .err_count_o         (errCount)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMiss = 0;
    logic [7:0] txLog[$];
    int busyHold = 0;
    int busyLeft = 0;
    int txStartCnt = 0;
    int setSeedCnt = 0, resetHistCnt = 0, resetOutCnt = 0, resetClockCnt = 0;

    // Transmitter model: logs every sent byte and holds tx_busy for busyHold cycles
    always @(negedge clk) begin
        if (bus.tx_start) txStartCnt++;
        if (reset) begin
            busyLeft = 0;
        end else if (bus.tx_start) begin
            txLog.push_back(bus.tx_data);
            busyLeft = busyHold;
        end else if (busyLeft > 0) begin
            busyLeft--;
        end
        bus.tx_busy = (busyLeft > 0);
        if (setSeed)    setSeedCnt++;
        if (resetHist)  resetHistCnt++;
        if (resetOut)   resetOutCnt++;
        if (resetClock) resetClockCnt++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReply(input int n, input int budget);
        int t;
        t = 0;
        while (txLog.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        idleCycles(6);
    endtask

    function automatic logic [63:0] fieldVal(input int f);
        case (f)
            F_COINC:    fieldVal = 64'(coincTime);
            F_DEAD:     fieldVal = 64'(deadTime);
            F_TRIG:     fieldVal = 64'(trigNum);
            F_NLAYER:   fieldVal = 64'(nLayer);
            F_NHIT:     fieldVal = 64'(nHit);
            F_MASK:     fieldVal = trigMask;
            F_PRESCALE: fieldVal = 64'(prescale);
            F_SEED:     fieldVal = 64'(seed);
            default:    fieldVal = 64'h0;
        endcase
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " coinc"},    64'(coincTime), 64'd20);
        checkOutput({tag, " dead"},     64'(deadTime),  64'd50);
        checkOutput({tag, " trignum"},  64'(trigNum),   64'd0);
        checkOutput({tag, " nlayer"},   64'(nLayer),    64'd0);
        checkOutput({tag, " nhit"},     64'(nHit),      64'd0);
        checkOutput({tag, " mask"},     trigMask,       64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput({tag, " prescale"}, 64'(prescale),  64'hFFFF_FFFF);
        checkOutput({tag, " seed"},     64'(seed),      64'd0);
        checkOutput({tag, " err"},      64'(errCount),  64'd0);
        checkOutput({tag, " tx_start"}, 64'(bus.tx_start), 64'd0);
        checkOutput({tag, " tx_data"},  64'(bus.tx_data),  64'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[15];
        vec_t v;
        int base, startSnap, t;
        logic [7:0] expByte;
        logic [31:0] histWord;

        vecs[0]  = '{8'h00, 0, 64'h0,                   F_NONE,     64'h0,                   8'd0, 1, 64'h09};
        vecs[1]  = '{8'h01, 1, 64'h28,                  F_COINC,    64'h28,                  8'd0, 0, 64'h0};
        vecs[2]  = '{8'h01, 1, 64'h50,                  F_COINC,    64'h28,                  8'd1, 0, 64'h0};
        vecs[3]  = '{8'h01, 1, 64'h3F,                  F_COINC,    64'h3F,                  8'd1, 0, 64'h0};
        vecs[4]  = '{8'h01, 1, 64'h40,                  F_COINC,    64'h3F,                  8'd2, 0, 64'h0};
        vecs[5]  = '{8'h0E, 8, 64'h0807060504030201,    F_MASK,     64'h0807060504030201,    8'd2, 0, 64'h0};
        vecs[6]  = '{8'h0B, 1, 64'h77,                  F_DEAD,     64'h77,                  8'd2, 0, 64'h0};
        vecs[7]  = '{8'h0F, 1, 64'h05,                  F_TRIG,     64'h05,                  8'd2, 0, 64'h0};
        vecs[8]  = '{8'h13, 1, 64'h03,                  F_NLAYER,   64'h03,                  8'd2, 0, 64'h0};
        vecs[9]  = '{8'h14, 1, 64'h04,                  F_NHIT,     64'h04,                  8'd2, 0, 64'h0};
        vecs[10] = '{8'h07, 4, 64'h12345678,            F_PRESCALE, 64'h12345678,            8'd2, 0, 64'h0};
        vecs[11] = '{8'h06, 4, 64'hCAFEBABE,            F_SEED,     64'hCAFEBABE,            8'd2, 0, 64'h0};
        vecs[12] = '{8'h15, 0, 64'h0,                   F_NONE,     64'h0,                   8'd2, 5, 64'h0000_0004_0305_773F};
        vecs[13] = '{8'h42, 0, 64'h0,                   F_NONE,     64'h0,                   8'd3, 1, 64'hFF};
        vecs[14] = '{8'h11, 0, 64'h0,                   F_NONE,     64'h0,                   8'd3, 1, 64'h11};

        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        for (int c = 0; c < NCH; c++) begin
            histos[c*HIST_W +: HIST_W] = 32'hA0B0C0D0 + 32'(c);
            for (int b = 0; b < CNT_W/8; b++) counters[c*CNT_W + b*8 +: 8] = 8'(c*16 + b);
            trigFired[c*8 +: 8] = 8'hE0 + 8'(c);
        end

        idleCycles(3);
        checkResetValues("reset");
        reset = 1'b0;
        idleCycles(2);

        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            txLog.delete();
            applyStimulus(v.op);
            for (int a = 0; a < v.nArgs; a++) applyStimulus(v.args[a*8 +: 8]);
            waitReply(v.expLen, 200);
            checkOutput($sformatf("vec%0d reply length", i), 64'(txLog.size()), 64'(v.expLen));
            for (int k = 0; k < v.expLen && k < 8; k++) begin
                if (k < txLog.size())
                    checkOutput($sformatf("vec%0d reply byte %0d", i, k), 64'(txLog[k]), 64'(v.expReply[k*8 +: 8]));
            end
            if (v.field != F_NONE)
                checkOutput($sformatf("vec%0d field", i), fieldVal(v.field), v.expField);
            checkOutput($sformatf("vec%0d err_count", i), 64'(errCount), 64'(v.expErr));
            checkOutput($sformatf("vec%0d state idle", i), 64'(dut.state_q), 64'(ST_IDLE));
        end
        checkOutput("set_seed pulse count", 64'(setSeedCnt), 64'd1);
        checkOutput("reset_clock pulse count", 64'(resetClockCnt), 64'd1);

        // Histogram reply: the source is cleared as soon as reset_hist is seen
        txLog.delete();
        startSnap = resetHistCnt;
        applyStimulus(8'h0A);
        t = 0;
        while (!resetHist && t < 20) begin
            @(negedge clk);
            t++;
        end
        histos = '0;
        waitReply(32, 400);
        checkOutput("hist reply length", 64'(txLog.size()), 64'd32);
        for (int k = 0; k < 32 && k < txLog.size(); k++) begin
            histWord = 32'hA0B0C0D0 + 32'(k / 4);
            expByte  = histWord[(k % 4)*8 +: 8];
            checkOutput($sformatf("hist byte %0d", k), 64'(txLog[k]), 64'(expByte));
        end
        checkOutput("reset_hist pulse count", 64'(resetHistCnt - startSnap), 64'd1);

        // Argument gaps just under the timeout are accepted
        applyStimulus(8'h07);
        applyStimulus(8'h11);
        idleCycles(90);
        applyStimulus(8'h22);
        idleCycles(90);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        idleCycles(4);
        checkOutput("slow args prescale", 64'(prescale), 64'h44332211);
        checkOutput("slow args err", 64'(errCount), 64'd3);

        // Stalled argument stream times out
        applyStimulus(8'h07);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        idleCycles(TIMEOUT + 20);
        checkOutput("timeout prescale kept", 64'(prescale), 64'h44332211);
        checkOutput("timeout err", 64'(errCount), 64'd4);
        checkOutput("timeout state idle", 64'(dut.state_q), 64'(ST_IDLE));
        txLog.delete();
        applyStimulus(8'h00);
        waitReply(1, 50);
        checkOutput("post-timeout reply length", 64'(txLog.size()), 64'd1);
        if (txLog.size() > 0) checkOutput("post-timeout version", 64'(txLog[0]), 64'd9);

        // Error counter saturation
        txLog.delete();
        for (int n = 0; n < 260; n++) begin
            applyStimulus(8'h42);
            idleCycles(4);
        end
        checkOutput("err saturated", 64'(errCount), 64'd255);
        checkOutput("nak count", 64'(txLog.size()), 64'd260);

        // Counter reply against a slow transmitter
        busyHold = 50;
        txLog.delete();
        startSnap = resetOutCnt;
        applyStimulus(8'h10);
        waitReply(64, 64*60 + 100);
        checkOutput("counter reply length", 64'(txLog.size()), 64'd64);
        for (int k = 0; k < 64 && k < txLog.size(); k++) begin
            base = k / 8;
            expByte = (k % 8 < 7) ? 8'(base*16 + k % 8) : 8'hE0 + 8'(base);
            checkOutput($sformatf("counter byte %0d", k), 64'(txLog[k]), 64'(expByte));
        end
        checkOutput("reset_out pulse count", 64'(resetOutCnt - startSnap), 64'd1);

        // Reset in the middle of a reply aborts it
        idleCycles(60);
        txLog.delete();
        applyStimulus(8'h10);
        t = 0;
        while (txLog.size() < 5 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b1;
        idleCycles(3);
        reset = 1'b0;
        startSnap = txStartCnt;
        idleCycles(300);
        checkOutput("no tx_start after reset", 64'(txStartCnt - startSnap), 64'd0);
        checkOutput("bytes before reset", 64'(txLog.size()), 64'd5);
        checkOutput("state idle after reset", 64'(dut.state_q), 64'(ST_IDLE));
        checkResetValues("midreply");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
